// File: rtl/alu_step_sequencer.sv
// alu_step_sequencer: Moore control-step generator for a single-bus datapath.
// Runs fetch (T0..T2) and execute (T3..T6) for three-register ALU ops and
// HI/LO-writeback MUL/DIV, with wait states on memory-ready and ALU-done.
module alu_step_sequencer #(
  parameter int                 DATA_W   = 32,
  parameter int                 NUM_REGS = 16,
  parameter int                 OPC_W    = 5,
  parameter logic [OPC_W-1:0]   OPC_MUL  = 5'b01111,
  parameter logic [OPC_W-1:0]   OPC_DIV  = 5'b10000
) (
  input  logic                  Clock_i,
  input  logic                  Resetn_i,
  input  logic                  Run_i,
  input  logic [DATA_W-1:0]     IR_value_i,
  input  logic                  Mem_ready_i,
  input  logic                  Alu_done_i,
  output logic                  PCout_o,
  output logic                  MARin_o,
  output logic                  IncPC_o,
  output logic                  Zin_o,
  output logic                  ZLOout_o,
  output logic                  ZHIout_o,
  output logic                  PCin_o,
  output logic                  Read_o,
  output logic                  MDRin_o,
  output logic                  MDRout_o,
  output logic                  IRin_o,
  output logic                  Yin_o,
  output logic                  HIin_o,
  output logic                  LOin_o,
  output logic [NUM_REGS-1:0]   Rout_o,
  output logic [NUM_REGS-1:0]   Rin_o,
  output logic [OPC_W-1:0]      ALU_op_o,
  output logic [3:0]            Step_o,
  output logic                  Busy_o,
  output logic                  Done_o
);

  localparam int REG_SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Register fields sit directly below the opcode, MSB-first: Ra, Rb, Rc.
  localparam int RA_LSB = DATA_W - OPC_W - REG_SEL_W;
  localparam int RB_LSB = RA_LSB - REG_SEL_W;
  localparam int RC_LSB = RB_LSB - REG_SEL_W;

  // Step codes are visible on Step_o, so the encoding is fixed.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_e;

  state_e                 state_q, state_d;
  logic                   t1_hold_q;   // previous cycle was already T1
  logic [OPC_W-1:0]       opcode_s;
  logic [REG_SEL_W-1:0]   ra_s, rb_s, rc_s;
  logic                   mul_div_s;

  // One-hot register select; an index at or above NUM_REGS selects nothing.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      oh[i] = (sel == REG_SEL_W'(i));
    end
    return oh;
  endfunction

  assign opcode_s  = IR_value_i[DATA_W-1 -: OPC_W];
  assign ra_s      = IR_value_i[RA_LSB +: REG_SEL_W];
  assign rb_s      = IR_value_i[RB_LSB +: REG_SEL_W];
  assign rc_s      = IR_value_i[RC_LSB +: REG_SEL_W];
  assign mul_div_s = (opcode_s == OPC_MUL) || (opcode_s == OPC_DIV);

  // IR bits below the register fields carry no control information.
  generate
    if (RC_LSB > 0) begin : g_ir_tail
      logic unused_ir_tail_s;
      assign unused_ir_tail_s = ^IR_value_i[RC_LSB-1:0];
    end
  endgenerate

  // State register plus the first-T1-cycle tracker used to gate PCin.
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      state_q   <= S_IDLE;
      t1_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_hold_q <= (state_q == S_T1);
    end
  end

  // Next-state logic, including memory and ALU wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Run_i) state_d = S_T0;
        else       state_d = S_IDLE;
      end
      S_T0: state_d = S_T1;
      S_T1: begin
        if (Mem_ready_i) state_d = S_T2;
        else             state_d = S_T1;
      end
      S_T2: state_d = S_T3;
      S_T3: state_d = S_T4;
      S_T4: begin
        if (mul_div_s && !Alu_done_i) state_d = S_T4;
        else                          state_d = S_T5;
      end
      S_T5: begin
        if (mul_div_s) state_d = S_T6;
        else           state_d = S_DONE;
      end
      S_T6:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode: at most one bus driver per state.
  always_comb begin
    PCout_o  = 1'b0;
    MARin_o  = 1'b0;
    IncPC_o  = 1'b0;
    Zin_o    = 1'b0;
    ZLOout_o = 1'b0;
    ZHIout_o = 1'b0;
    PCin_o   = 1'b0;
    Read_o   = 1'b0;
    MDRin_o  = 1'b0;
    MDRout_o = 1'b0;
    IRin_o   = 1'b0;
    Yin_o    = 1'b0;
    HIin_o   = 1'b0;
    LOin_o   = 1'b0;
    Rout_o   = '0;
    Rin_o    = '0;
    ALU_op_o = '0;
    Done_o   = 1'b0;
    Busy_o   = (state_q != S_IDLE);
    Step_o   = state_q;
    case (state_q)
      S_T0: begin
        PCout_o = 1'b1;
        MARin_o = 1'b1;
        IncPC_o = 1'b1;
        Zin_o   = 1'b1;
      end
      S_T1: begin
        ZLOout_o = 1'b1;
        PCin_o   = !t1_hold_q;   // load PC once even if the read stalls
        Read_o   = 1'b1;
        MDRin_o  = 1'b1;
      end
      S_T2: begin
        MDRout_o = 1'b1;
        IRin_o   = 1'b1;
      end
      S_T3: begin
        Rout_o   = reg_onehot(rb_s);
        Yin_o    = 1'b1;
        ALU_op_o = opcode_s;
      end
      S_T4: begin
        Rout_o   = reg_onehot(rc_s);
        Zin_o    = 1'b1;
        ALU_op_o = opcode_s;
      end
      S_T5: begin
        ZLOout_o = 1'b1;
        ALU_op_o = opcode_s;
        if (mul_div_s) begin
          LOin_o = 1'b1;
        end else begin
          Rin_o  = reg_onehot(ra_s);
        end
      end
      S_T6: begin
        ZHIout_o = 1'b1;
        HIin_o   = 1'b1;
        ALU_op_o = opcode_s;
      end
      S_DONE: Done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer with a small single-bus datapath model.
module tb_alu_step_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run, mem_ready, alu_done;
  logic [31:0] irr;
  logic        pcout, marin, incpc, zin, zloout, zhiout, pcin, read, mdrin, mdrout, irin, yin, hiin, loin;
  logic [15:0] rout, rin;
  logic [4:0]  alu_op;
  logic [3:0]  step;
  logic        busy, done;

  alu_step_sequencer dut (
    .Clock_i(clk), .Resetn_i(rst_n), .Run_i(run), .IR_value_i(irr),
    .Mem_ready_i(mem_ready), .Alu_done_i(alu_done),
    .PCout_o(pcout), .MARin_o(marin), .IncPC_o(incpc), .Zin_o(zin),
    .ZLOout_o(zloout), .ZHIout_o(zhiout), .PCin_o(pcin), .Read_o(read),
    .MDRin_o(mdrin), .MDRout_o(mdrout), .IRin_o(irin), .Yin_o(yin),
    .HIin_o(hiin), .LOin_o(loin), .Rout_o(rout), .Rin_o(rin),
    .ALU_op_o(alu_op), .Step_o(step), .Busy_o(busy), .Done_o(done)
  );

  // Reduced-size builds driven directly with IR values.
  logic        run_p;
  logic [31:0] ir8, ir12;
  logic [13:0] unused8_strb, unused12_strb;
  logic [4:0]  unused8_op, unused12_op;
  logic        unused8_busy, unused8_done, unused12_busy, unused12_done;
  logic [3:0]  unused12_step, step8;
  logic [7:0]  rout8, rin8;
  logic [11:0] rout12, rin12;

  alu_step_sequencer #(.NUM_REGS(8)) dut8 (
    .Clock_i(clk), .Resetn_i(rst_n), .Run_i(run_p), .IR_value_i(ir8),
    .Mem_ready_i(1'b1), .Alu_done_i(1'b1),
    .PCout_o(unused8_strb[13]), .MARin_o(unused8_strb[12]), .IncPC_o(unused8_strb[11]),
    .Zin_o(unused8_strb[10]), .ZLOout_o(unused8_strb[9]), .ZHIout_o(unused8_strb[8]),
    .PCin_o(unused8_strb[7]), .Read_o(unused8_strb[6]), .MDRin_o(unused8_strb[5]),
    .MDRout_o(unused8_strb[4]), .IRin_o(unused8_strb[3]), .Yin_o(unused8_strb[2]),
    .HIin_o(unused8_strb[1]), .LOin_o(unused8_strb[0]), .Rout_o(rout8), .Rin_o(rin8),
    .ALU_op_o(unused8_op), .Step_o(step8), .Busy_o(unused8_busy), .Done_o(unused8_done)
  );

  alu_step_sequencer #(.NUM_REGS(12)) dut12 (
    .Clock_i(clk), .Resetn_i(rst_n), .Run_i(run_p), .IR_value_i(ir12),
    .Mem_ready_i(1'b1), .Alu_done_i(1'b1),
    .PCout_o(unused12_strb[13]), .MARin_o(unused12_strb[12]), .IncPC_o(unused12_strb[11]),
    .Zin_o(unused12_strb[10]), .ZLOout_o(unused12_strb[9]), .ZHIout_o(unused12_strb[8]),
    .PCin_o(unused12_strb[7]), .Read_o(unused12_strb[6]), .MDRin_o(unused12_strb[5]),
    .MDRout_o(unused12_strb[4]), .IRin_o(unused12_strb[3]), .Yin_o(unused12_strb[2]),
    .HIin_o(unused12_strb[1]), .LOin_o(unused12_strb[0]), .Rout_o(rout12), .Rin_o(rin12),
    .ALU_op_o(unused12_op), .Step_o(unused12_step), .Busy_o(unused12_busy), .Done_o(unused12_done)
  );

  // Strobe order: PCout MARin IncPC Zin ZLOout ZHIout PCin Read MDRin MDRout IRin Yin HIin LOin
  logic [13:0] strb;
  logic [56:0] all_out;
  assign strb    = {pcout, marin, incpc, zin, zloout, zhiout, pcin, read, mdrin, mdrout, irin, yin, hiin, loin};
  assign all_out = {strb, rout, rin, alu_op, step, busy, done};

  // ---------------- datapath model ----------------
  logic [31:0] regs [16];
  logic [31:0] mem  [8];
  logic [31:0] pc, mdr, y, hi, lo, bus;
  logic [2:0]  mar;
  logic [63:0] z;

  // Bus mux driven by the sequencer's out-strobes.
  always_comb begin
    bus = 32'd0;
    if (pcout)  bus = pc;
    if (zloout) bus = z[31:0];
    if (zhiout) bus = z[63:32];
    if (mdrout) bus = mdr;
    for (int i = 0; i < 16; i++) if (rout[i]) bus = regs[i];
  end

  // Datapath registers loaded by the sequencer's in-strobes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= 32'd0; mar <= 3'd0; mdr <= 32'd0; irr <= 32'd0;
      y <= 32'd0; z <= 64'd0; hi <= 32'd0; lo <= 32'd0;
      for (int i = 0; i < 16; i++)
        regs[i] <= (i == 15) ? 32'hFFFF_FFF0 : 32'h0000_000C + 32'(4 * i);
    end else begin
      if (marin) mar <= bus[2:0];
      if (pcin)  pc  <= bus;
      if (read && mdrin && mem_ready) mdr <= mem[mar];
      if (irin)  irr <= bus;
      if (yin)   y   <= bus;
      if (loin)  lo  <= bus;
      if (hiin)  hi  <= bus;
      if (zin) begin
        if (incpc) z <= {32'd0, bus + 32'd1};
        else case (alu_op)
          5'd4:    z <= {32'd0, y - bus};
          5'd15:   z <= {32'd0, y} * {32'd0, bus};
          5'd16:   z <= {y % bus, y / bus};
          default: z <= {32'd0, y + bus};
        endcase
      end
      for (int i = 0; i < 16; i++) if (rin[i]) regs[i] <= bus;
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int bus_viol = 0;
  int lat;
  logic [3:0]  step_tr [1:40];
  logic [15:0] rout_tr [1:40];
  logic [15:0] rin_tr  [1:40];
  logic [13:0] strb_tr [1:40];
  logic [4:0]  op_tr   [1:40];
  logic        busy_tr [1:40];
  logic [15:0] rin_or;
  logic        zin_and, busy_and;
  logic [2:0]  ra8, rb8, rc8;
  logic [3:0]  ra12, rb12, rc12;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic logic [7:0] oh8(input logic [2:0] s);
    return 8'd1 << s;
  endfunction

  function automatic logic [11:0] oh12(input logic [3:0] s);
    return (s < 4'd12) ? (12'd1 << s) : 12'd0;
  endfunction

  // Pulse Run, trace every cycle until Done (bounded), releasing the waits after the given counts.
  task automatic run_instr(input int mr_wait, input int ad_wait, input logic run_mid, output int lat_o);
    int t1c, t4c, drv;
    t1c = 0; t4c = 0; lat_o = 0;
    mem_ready = (mr_wait == 0);
    alu_done  = (ad_wait == 0);
    @(negedge clk); run = 1'b1;
    for (int c = 1; c <= 40 && lat_o == 0; c++) begin
      @(negedge clk);
      run = run_mid && (step == 4'd4 || step == 4'd8);
      step_tr[c] = step; rout_tr[c] = rout; rin_tr[c] = rin;
      strb_tr[c] = strb; op_tr[c] = alu_op; busy_tr[c] = busy;
      drv = int'(pcout) + int'(zloout) + int'(zhiout) + int'(mdrout) + $countones(rout);
      if (drv > 1) bus_viol++;
      if (step == 4'd2) begin t1c++; mem_ready = (mr_wait == 0) || (t1c > mr_wait); end
      if (step == 4'd5) begin t4c++; alu_done  = (ad_wait == 0) || (t4c > ad_wait); end
      if (done) lat_o = c;
    end
    run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 32'h1891_8000;        // add R1 = R2 + R3
    mem[1] = mk(5'd4,  4'd6, 4'd3, 4'd2);   // sub R6 = R3 - R2
    mem[2] = mk(5'd15, 4'd7, 4'd15, 4'd15); // mul R15 * R15
    mem[3] = mk(5'd3,  4'd8, 4'd1, 4'd6);   // add R8 = R1 + R6
    mem[4] = mk(5'd16, 4'd9, 4'd3, 4'd2);   // div R3 / R2
    mem[5] = mk(5'd3,  4'd10, 4'd2, 4'd3);
    mem[6] = 32'd0; mem[7] = 32'd0;
    rst_n = 1'b0; run = 1'b0; run_p = 1'b0; mem_ready = 1'b0; alu_done = 1'b0;
    ir8 = 32'd0; ir12 = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outputs", 64'(all_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_step", 64'(step), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Add, no waits
    run_instr(0, 0, 1'b0, lat);
    chk("add_lat", 64'(lat), 64'd7);
    chk("add_t0_step", 64'(step_tr[1]), 64'd1);
    chk("add_t0_strb", 64'(strb_tr[1]), 64'(14'b11110000000000));
    chk("add_t1_strb", 64'(strb_tr[2]), 64'(14'b00001011100000));
    chk("add_t2_strb", 64'(strb_tr[3]), 64'(14'b00000000011000));
    chk("add_t3_step", 64'(step_tr[4]), 64'd4);
    chk("add_t3_rout", 64'(rout_tr[4]), 64'h0004);
    chk("add_t3_op",   64'(op_tr[4]), 64'd3);
    chk("add_t2_op",   64'(op_tr[3]), 64'd0);
    chk("add_t4_rout", 64'(rout_tr[5]), 64'h0008);
    chk("add_t4_strb", 64'(strb_tr[5]), 64'(14'b00010000000000));
    chk("add_t5_step", 64'(step_tr[6]), 64'd6);
    chk("add_t5_rin",  64'(rin_tr[6]), 64'h0002);
    chk("add_t5_strb", 64'(strb_tr[6]), 64'(14'b00001000000000));
    chk("add_done_step", 64'(step_tr[7]), 64'd8);
    chk("add_done_op", 64'(op_tr[7]), 64'd0);
    chk("add_r1", 64'(regs[1]), 64'h2C);
    chk("add_pc", 64'(pc), 64'd1);
    @(negedge clk);
    chk("add_back_idle", 64'(step), 64'd0);
    chk("add_done_pulse", 64'(done), 64'd0);

    // Fetch wait: memory not ready for 3 T1 cycles
    run_instr(3, 0, 1'b0, lat);
    chk("fw_lat", 64'(lat), 64'd10);
    chk("fw_t1_steps", 64'({step_tr[2], step_tr[3], step_tr[4], step_tr[5]}), 64'h2222);
    chk("fw_t1_after", 64'(step_tr[6]), 64'd3);
    chk("fw_pcin", 64'({strb_tr[2][7], strb_tr[3][7], strb_tr[4][7], strb_tr[5][7]}), 64'b1000);
    chk("fw_t1_hold_strb", 64'(strb_tr[4]), 64'(14'b00001001100000));
    chk("fw_pc", 64'(pc), 64'd2);
    chk("fw_r6", 64'(regs[6]), 64'd4);

    // MUL with ALU wait: Alu_done on the 5th T4 cycle
    run_instr(0, 4, 1'b0, lat);
    rin_or = 16'd0; zin_and = 1'b1;
    for (int c = 1; c <= 12; c++) rin_or |= rin_tr[c];
    for (int c = 5; c <= 9; c++) zin_and &= (step_tr[c] == 4'd5) && strb_tr[c][10];
    chk("mul_lat", 64'(lat), 64'd12);
    chk("mul_t4_hold_zin", 64'(zin_and), 64'd1);
    chk("mul_t3_rout", 64'(rout_tr[4]), 64'h8000);
    chk("mul_t5_step", 64'(step_tr[10]), 64'd6);
    chk("mul_t5_strb", 64'(strb_tr[10]), 64'(14'b00001000000001));
    chk("mul_t6_step", 64'(step_tr[11]), 64'd7);
    chk("mul_t6_strb", 64'(strb_tr[11]), 64'(14'b00000100000010));
    chk("mul_t6_op", 64'(op_tr[11]), 64'd15);
    chk("mul_no_rin", 64'(rin_or), 64'd0);
    chk("mul_lo", 64'(lo), 64'h0000_0100);
    chk("mul_hi", 64'(hi), 64'hFFFF_FFE0);
    chk("mul_r7_kept", 64'(regs[7]), 64'h28);

    // Run during T3 and DONE is ignored
    run_instr(0, 0, 1'b1, lat);
    busy_and = 1'b1;
    for (int c = 1; c <= 7; c++) busy_and &= busy_tr[c];
    chk("ign_lat", 64'(lat), 64'd7);
    chk("ign_busy", 64'(busy_and), 64'd1);
    chk("ign_t4_step", 64'(step_tr[5]), 64'd5);
    chk("ign_r8", 64'(regs[8]), 64'h30);
    repeat (3) begin
      @(negedge clk);
      chk("ign_stay_idle", 64'({busy, step}), 64'd0);
    end

    // DIV with Alu_done already high: minimum 8-cycle latency
    run_instr(0, 0, 1'b0, lat);
    chk("div_lat", 64'(lat), 64'd8);
    chk("div_t6_step", 64'(step_tr[7]), 64'd7);
    chk("div_lo", 64'(lo), 64'd1);
    chk("div_hi", 64'(hi), 64'd4);

    // Reset mid-T4, then restart
    mem_ready = 1'b1; alu_done = 1'b1;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_t4", 64'(step), 64'd5);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_out", 64'(all_out), 64'd0);
    @(negedge clk);
    chk("rst_held_out", 64'(all_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_idle", 64'(step), 64'd0);
    run_instr(0, 0, 1'b0, lat);
    chk("rst_restart_t0", 64'(step_tr[1]), 64'd1);
    chk("rst_restart_lat", 64'(lat), 64'd7);
    chk("rst_restart_r1", 64'(regs[1]), 64'h2C);
    chk("bus_single_driver", 64'(bus_viol), 64'd0);

    // Reduced builds: one-hot sweep (NUM_REGS=8) and out-of-range indices (NUM_REGS=12)
    for (int i = 0; i < 16; i++) begin
      rb8 = 3'(i); ra8 = rb8 + 3'd1; rc8 = rb8 + 3'd3;
      rb12 = 4'(i); ra12 = 4'(15 - i); rc12 = rb12 + 4'd2;
      ir8  = {5'd3, ra8, rb8, rc8, 18'd0};
      ir12 = {5'd3, ra12, rb12, rc12, 15'd0};
      @(negedge clk); run_p = 1'b1;
      @(negedge clk); run_p = 1'b0;
      repeat (3) @(negedge clk);
      chk("p8_t3_step", 64'(step8), 64'd4);
      chk("p8_t3_rout", 64'(rout8), 64'(oh8(rb8)));
      chk("p12_t3_rout", 64'(rout12), 64'(oh12(rb12)));
      @(negedge clk);
      chk("p8_t4_rout", 64'(rout8), 64'(oh8(rc8)));
      chk("p12_t4_rout", 64'(rout12), 64'(oh12(rc12)));
      @(negedge clk);
      chk("p8_t5_rin", 64'(rin8), 64'(oh8(ra8)));
      chk("p12_t5_rin", 64'(rin12), 64'(oh12(ra12)));
      repeat (2) @(negedge clk);
      chk("p8_idle", 64'(step8), 64'd0);
    end
    chk("p8_rb5", 64'(oh8(3'd5)), 64'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_step_sequencer.md
Name: alu_step_sequencer

Overview:
- Hardware control-step generator. Replaces hand-sequenced T0..T5 stimulus with a parametrised Moore FSM.
- Drives the datapath register enables to run fetch and execute for three-register ALU instructions (add/sub/logic), plus two-writeback MUL/DIV.
- Sits between the future control unit and the datapath. Adds memory-ready and ALU-done wait states that the fixed-timing sequence lacks.

Parameters:
- DATA_W, 32, instruction/IR width
- NUM_REGS, 16, general registers; REG_SEL_W = clog2(NUM_REGS)
- OPC_W, 5, opcode field width
- OPC_MUL, 5'b01111, opcode needing HI/LO writeback
- OPC_DIV, 5'b10000, opcode needing HI/LO writeback

Ports:
- Clock, in, 1, system clock, rising edge
- Resetn, in, 1, asynchronous active-low reset
- Run, in, 1, start one instruction when idle
- IR_value, in, DATA_W, current IR contents (datapath IR output)
- Mem_ready, in, 1, memory read data valid
- Alu_done, in, 1, multi-cycle ALU result valid
- PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin, out, 1 each, datapath control strobes
- Rout, out, NUM_REGS, one-hot general-register bus drive
- Rin, out, NUM_REGS, one-hot general-register load
- ALU_op, out, OPC_W, opcode to ALU
- Step, out, 4, encoded current state
- Busy, out, 1, high in any state except IDLE
- Done, out, 1, one-cycle pulse at end of instruction

Behaviour:
- Resetn low, asynchronous: state=IDLE, every output 0, Step=0. Reset mid-instruction abandons it; no strobe glitches after assertion.
- Outputs are Moore, decoded from registered state only. At most one bus driver is high in any state.
- Field decode, MSB-first:
  - opcode = IR_value[DATA_W-1 -: OPC_W]
  - Ra = next REG_SEL_W bits; Rb = next; Rc = next
  - Example: 32'h18918000 gives opcode 3, Ra=1, Rb=2, Rc=3.
- ALU_op = opcode in T3..T6, else 0.
- States, with Step code:
  - IDLE(0): Run=1 -> T0.
  - T0(1): PCout, MARin, IncPC, Zin -> T1.
  - T1(2): ZLOout, PCin, Read, MDRin. Stays in T1 while Mem_ready=0. PCin is asserted only on the first T1 cycle, so PC increments once. Mem_ready=1 -> T2.
  - T2(3): MDRout, IRin -> T3.
  - T3(4): Rout[Rb], Yin -> T4.
  - T4(5): Rout[Rc], Zin.
    - Non-MUL/DIV -> T5.
    - MUL/DIV: holds while Alu_done=0; Zin stays high throughout. Alu_done=1 -> T5.
  - T5(6):
    - Normal: ZLOout, Rin[Ra] -> DONE.
    - MUL/DIV: ZLOout, LOin -> T6.
  - T6(7): ZHIout, HIin -> DONE.
  - DONE(8): Done=1 for one cycle -> IDLE. Run is ignored here.
- Run while Busy is ignored; no queueing.
- Ra/Rb/Rc index at or above NUM_REGS (non-power-of-two NUM_REGS): no Rout/Rin bit asserted.
- Rb==Rc is legal; the same register is driven in T3 and T4.
- Ra==Rb is legal; writeback happens only in T5.
- Mem_ready/Alu_done already high on state entry: no wait cycles. Minimum latency is 7 cycles Run->Done for normal ops, 8 for MUL/DIV.
- Unused Step codes recover to IDLE.

Test Plan:
- Reset: Resetn=0 mid-T4 -> all outputs 0 and Step=0 immediately. After release, Run=1 restarts at T0.
- Add, no waits: preload R2=0x14, R3=0x18, IR fetch 32'h18918000, Mem_ready=1 -> Steps 1,2,3,4,5,6,8. Rout=16'h0004 in T3, 16'h0008 in T4, Rin=16'h0002 in T5. Datapath R1=0x2C. Done pulses at cycle 7.
- Fetch wait: Mem_ready low for 3 cycles in T1 -> Step=2 for 4 cycles, PCin high only on the first. PC increments by exactly 1. Done at cycle 10.
- MUL: opcode 5'b01111, Alu_done after 5 cycles in T4 -> LOin in T5, HIin in T6, no Rin bits asserted, Done at cycle 12.
- Run asserted during T3 and DONE -> ignored. Busy=1 throughout; returns to IDLE and stays.
- Parametrised build NUM_REGS=8, REG_SEL_W=3: IR Rb=3'd5 -> Rout=8'h20 in T3; one-hot check over all indices.
